// File: rtl/reg_write_scheduler_pkg.sv
// rtl/reg_write_scheduler_pkg.sv - shared widths, constants and types for the RegFile write scheduler
package reg_write_scheduler_pkg;
    localparam int REG_ADDR_BUS = 5;
    localparam int WORD_BUS     = 32;
    localparam int REG_NUM      = 32;

    localparam logic [REG_ADDR_BUS-1:0] REG_ZERO  = '0;
    localparam logic [WORD_BUS-1:0]     ZERO_WORD = '0;
    localparam logic                    ENABLE    = 1'b1;
    localparam logic                    DISABLE   = 1'b0;

    typedef logic [REG_ADDR_BUS-1:0] reg_addr_t;
    typedef logic [WORD_BUS-1:0]     word_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_WB   = 2'd1,
        SRC_BUF  = 2'd2
    } wr_src_e;
endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - pending-destination busy vector and outstanding long-op counter
module reg_scoreboard
    import reg_write_scheduler_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CW              = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_set_en,
    input  reg_addr_t          i_set_addr,
    input  logic               i_clr_en,
    input  reg_addr_t          i_clr_addr,
    input  reg_addr_t          i_addr_a,
    input  reg_addr_t          i_addr_b,
    input  reg_addr_t          i_addr_c,
    output logic               o_busy_a,
    output logic               o_busy_b,
    output logic               o_busy_c,
    output logic               o_full,
    output logic [REG_NUM-1:0] o_busy
);
    logic [REG_NUM-1:0] r_busy;
    logic [CW-1:0]      r_count;
    logic [REG_NUM-1:0] w_busy_next;

    // Clear first, then set, so a same-cycle set of the same register wins.
    always_comb begin
        w_busy_next = r_busy;
        if (i_clr_en) w_busy_next[i_clr_addr] = DISABLE;
        if (i_set_en) w_busy_next[i_set_addr] = ENABLE;
        w_busy_next[0] = DISABLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy  <= '0;
            r_count <= '0;
        end else begin
            r_busy <= w_busy_next;
            if (i_set_en && !i_clr_en) begin
                r_count <= r_count + CW'(1);
            end else if (!i_set_en && i_clr_en && r_count != '0) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && i_clr_en) begin
            assert (r_count != '0);
        end
    end

    assign o_busy_a = r_busy[i_addr_a];
    assign o_busy_b = r_busy[i_addr_b];
    assign o_busy_c = r_busy[i_addr_c];
    assign o_full   = (r_count == CW'(MAX_OUTSTANDING));
    assign o_busy   = r_busy;
endmodule

// File: rtl/reg_write_scheduler.sv
// rtl/reg_write_scheduler.sv - shares the RegFile write port between MEM/WB and the long-latency unit
module reg_write_scheduler
    import reg_write_scheduler_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_issue_valid,
    input  logic [4:0]         i_issue_dest,
    input  logic               i_id_read_en_l,
    input  logic [4:0]         i_id_read_addr_l,
    input  logic               i_id_read_en_r,
    input  logic [4:0]         i_id_read_addr_r,
    input  logic               i_id_write_en,
    input  logic [4:0]         i_id_dest,
    input  logic               i_wb_we,
    input  logic [4:0]         i_wb_addr,
    input  logic [31:0]        i_wb_data,
    input  logic               i_lu_valid,
    input  logic [4:0]         i_lu_dest,
    input  logic [31:0]        i_lu_data,
    output logic               o_lu_ready,
    output logic               o_rf_we,
    output logic [4:0]         o_rf_addr,
    output logic [31:0]        o_rf_data,
    output logic               o_id_stall,
    output logic               o_pipe_hold,
    output logic [31:0]        o_pending
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic      r_buf_valid;
    reg_addr_t r_buf_dest;
    word_t     r_buf_data;
    logic [SW-1:0] r_starve;
    logic      r_pipe_hold;

    logic      w_wb_active;
    logic      w_drain;
    logic      w_blocked;
    logic      w_lu_ready;
    logic      w_accept;
    logic      w_issue;
    logic      w_stall;
    logic      w_hold_next;
    logic      w_busy_l;
    logic      w_busy_r;
    logic      w_busy_d;
    logic      w_full;
    logic [REG_NUM-1:0] w_pending;
    wr_src_e   w_src;

    reg_scoreboard #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .i_set_en   (w_issue),
        .i_set_addr (i_issue_dest),
        .i_clr_en   (w_drain),
        .i_clr_addr (r_buf_dest),
        .i_addr_a   (i_id_read_addr_l),
        .i_addr_b   (i_id_read_addr_r),
        .i_addr_c   (i_id_dest),
        .o_busy_a   (w_busy_l),
        .o_busy_b   (w_busy_r),
        .o_busy_c   (w_busy_d),
        .o_full     (w_full),
        .o_busy     (w_pending)
    );

    assign w_wb_active = i_wb_we && (i_wb_addr != REG_ZERO);
    assign w_drain     = r_buf_valid && !w_wb_active && !rst;
    assign w_blocked   = r_buf_valid && w_wb_active;
    // A single-entry buffer without bypass: accept only when empty.
    assign w_lu_ready  = !r_buf_valid;
    assign w_accept    = i_lu_valid && w_lu_ready && !rst;

    assign w_stall = (i_id_read_en_l && w_busy_l)
                  || (i_id_read_en_r && w_busy_r)
                  || (i_id_write_en  && w_busy_d)
                  || (i_issue_valid  && (w_pending[i_issue_dest] || w_full))
                  || r_pipe_hold;
    assign w_issue = i_issue_valid && !w_stall && !rst;

    // Hold stays up through the drain cycle and drops once the buffer empties.
    assign w_hold_next = ((r_starve == SW'(STARVE_LIMIT - 1)) && w_blocked)
                      || (r_pipe_hold && r_buf_valid && !w_drain);

    always_comb begin
        w_src = SRC_NONE;
        if (!rst) begin
            if (w_wb_active) begin
                w_src = SRC_WB;
            end else if (r_buf_valid && r_buf_dest != REG_ZERO) begin
                w_src = SRC_BUF;
            end
        end
    end

    always_comb begin
        o_rf_we   = DISABLE;
        o_rf_addr = REG_ZERO;
        o_rf_data = ZERO_WORD;
        case (w_src)
            SRC_WB: begin
                o_rf_we   = ENABLE;
                o_rf_addr = i_wb_addr;
                o_rf_data = i_wb_data;
            end
            SRC_BUF: begin
                o_rf_we   = ENABLE;
                o_rf_addr = r_buf_dest;
                o_rf_data = r_buf_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf_valid <= DISABLE;
            r_buf_dest  <= REG_ZERO;
            r_buf_data  <= ZERO_WORD;
            r_starve    <= '0;
            r_pipe_hold <= DISABLE;
        end else begin
            if (w_accept) begin
                r_buf_valid <= ENABLE;
                r_buf_dest  <= i_lu_dest;
                r_buf_data  <= i_lu_data;
            end else if (w_drain) begin
                r_buf_valid <= DISABLE;
            end
            if (w_drain) begin
                r_starve <= '0;
            end else if (w_blocked && r_starve != SW'(STARVE_LIMIT)) begin
                r_starve <= r_starve + SW'(1);
            end
            r_pipe_hold <= w_hold_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept && i_lu_dest != REG_ZERO) begin
            assert (w_pending[i_lu_dest]);
        end
    end

    assign o_lu_ready  = w_lu_ready && !rst;
    assign o_id_stall  = w_stall && !rst;
    assign o_pipe_hold = r_pipe_hold;
    assign o_pending   = w_pending;
endmodule

// File: tb/tb_reg_write_scheduler.sv
// tb/tb_reg_write_scheduler.sv - directed self-checking bench for reg_write_scheduler
module tb_reg_write_scheduler;
    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_dest;
    logic        rd_en_l;
    logic [4:0]  rd_addr_l;
    logic        rd_en_r;
    logic [4:0]  rd_addr_r;
    logic        id_we;
    logic [4:0]  id_dest;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        lu_valid;
    logic [4:0]  lu_dest;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic        id_stall;
    logic        pipe_hold;
    logic [31:0] pending;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    reg_write_scheduler #(
        .MAX_OUTSTANDING(4),
        .STARVE_LIMIT   (3)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_issue_valid    (issue_valid),
        .i_issue_dest     (issue_dest),
        .i_id_read_en_l   (rd_en_l),
        .i_id_read_addr_l (rd_addr_l),
        .i_id_read_en_r   (rd_en_r),
        .i_id_read_addr_r (rd_addr_r),
        .i_id_write_en    (id_we),
        .i_id_dest        (id_dest),
        .i_wb_we          (wb_we),
        .i_wb_addr        (wb_addr),
        .i_wb_data        (wb_data),
        .i_lu_valid       (lu_valid),
        .i_lu_dest        (lu_dest),
        .i_lu_data        (lu_data),
        .o_lu_ready       (lu_ready),
        .o_rf_we          (rf_we),
        .o_rf_addr        (rf_addr),
        .o_rf_data        (rf_data),
        .o_id_stall       (id_stall),
        .o_pipe_hold      (pipe_hold),
        .o_pending        (pending)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        issue_valid = 1'b0; issue_dest = '0;
        rd_en_l = 1'b0; rd_addr_l = '0;
        rd_en_r = 1'b0; rd_addr_r = '0;
        id_we = 1'b0; id_dest = '0;
        wb_we = 1'b0; wb_addr = '0; wb_data = '0;
        lu_valid = 1'b0; lu_dest = '0; lu_data = '0;
    endtask

    task automatic issue(input logic [4:0] d);
        issue_valid = 1'b1; issue_dest = d;
        settle();
        chk("issue_no_stall", {31'b0, id_stall}, 32'd0);
        tick();
        issue_valid = 1'b0;
    endtask

    task automatic lu_return(input logic [4:0] d, input logic [31:0] v);
        lu_valid = 1'b1; lu_dest = d; lu_data = v;
        settle();
        chk("lu_ready_accept", {31'b0, lu_ready}, 32'd1);
        tick();
        lu_valid = 1'b0;
        settle();
        chk("drain_addr", {27'b0, rf_addr}, {27'b0, d});
        tick();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        rd_en_l = 1'b1; rd_addr_l = 5'd5;
        tick();
        tick();
        chk("rst_rf_we", {31'b0, rf_we}, 32'd0);
        chk("rst_lu_ready", {31'b0, lu_ready}, 32'd0);
        chk("rst_id_stall", {31'b0, id_stall}, 32'd0);
        chk("rst_pending", pending, 32'd0);
        chk("rst_pipe_hold", {31'b0, pipe_hold}, 32'd0);
        rst = 1'b0;
        idle();
        settle();
        chk("post_rst_lu_ready", {31'b0, lu_ready}, 32'd1);

        // Basic long op to r5, result three cycles after issue.
        issue(5'd5);
        rd_en_l = 1'b1; rd_addr_l = 5'd5;
        for (int c = 1; c <= 2; c++) begin
            settle();
            chk("basic_raw_stall", {31'b0, id_stall}, 32'd1);
            tick();
        end
        lu_valid = 1'b1; lu_dest = 5'd5; lu_data = 32'h1234;
        settle();
        chk("basic_accept_ready", {31'b0, lu_ready}, 32'd1);
        chk("basic_c3_stall", {31'b0, id_stall}, 32'd1);
        chk("basic_c3_no_we", {31'b0, rf_we}, 32'd0);
        tick();
        lu_valid = 1'b0;
        settle();
        chk("basic_c4_we", {31'b0, rf_we}, 32'd1);
        chk("basic_c4_addr", {27'b0, rf_addr}, 32'd5);
        chk("basic_c4_data", rf_data, 32'h1234);
        chk("basic_c4_ready", {31'b0, lu_ready}, 32'd0);
        chk("basic_c4_stall", {31'b0, id_stall}, 32'd1);
        chk("basic_c4_pending", pending, 32'h20);
        tick();
        chk("basic_c5_stall", {31'b0, id_stall}, 32'd0);
        chk("basic_c5_pending", pending, 32'd0);
        chk("basic_c5_no_we", {31'b0, rf_we}, 32'd0);
        rd_en_l = 1'b0;

        // Collision: buffered r7 starved by three back-to-back WB writes.
        issue(5'd7);
        lu_valid = 1'b1; lu_dest = 5'd7; lu_data = 32'h77;
        tick();
        lu_valid = 1'b0;
        wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'h33;
        settle();
        chk("coll_wb3_addr", {27'b0, rf_addr}, 32'd3);
        chk("coll_wb3_data", rf_data, 32'h33);
        chk("coll_wb3_hold", {31'b0, pipe_hold}, 32'd0);
        tick();
        wb_addr = 5'd4; wb_data = 32'h44;
        settle();
        chk("coll_wb4_addr", {27'b0, rf_addr}, 32'd4);
        chk("coll_wb4_hold", {31'b0, pipe_hold}, 32'd0);
        tick();
        wb_addr = 5'd9; wb_data = 32'h99;
        settle();
        chk("coll_wb9_addr", {27'b0, rf_addr}, 32'd9);
        chk("coll_wb9_ready", {31'b0, lu_ready}, 32'd0);
        tick();
        wb_we = 1'b0; wb_addr = '0; wb_data = '0;
        settle();
        chk("coll_hold_up", {31'b0, pipe_hold}, 32'd1);
        chk("coll_hold_stall", {31'b0, id_stall}, 32'd1);
        chk("coll_drain_we", {31'b0, rf_we}, 32'd1);
        chk("coll_drain_addr", {27'b0, rf_addr}, 32'd7);
        chk("coll_drain_data", rf_data, 32'h77);
        tick();
        chk("coll_hold_down", {31'b0, pipe_hold}, 32'd0);
        chk("coll_pending", pending, 32'd0);
        chk("coll_ready", {31'b0, lu_ready}, 32'd1);

        // Full scoreboard: four ops outstanding, fifth waits for a drain.
        issue(5'd1);
        issue(5'd2);
        issue(5'd3);
        issue(5'd4);
        chk("full_count", {29'b0, dut.u_sb.r_count}, 32'd4);
        issue_valid = 1'b1; issue_dest = 5'd10;
        settle();
        chk("full_stall_a", {31'b0, id_stall}, 32'd1);
        tick();
        lu_valid = 1'b1; lu_dest = 5'd1; lu_data = 32'h11;
        settle();
        chk("full_stall_b", {31'b0, id_stall}, 32'd1);
        tick();
        lu_valid = 1'b0;
        settle();
        chk("full_stall_drain", {31'b0, id_stall}, 32'd1);
        chk("full_drain_addr", {27'b0, rf_addr}, 32'd1);
        tick();
        settle();
        chk("full_released", {31'b0, id_stall}, 32'd0);
        tick();
        issue_valid = 1'b0;
        chk("full_pending", pending, 32'h0000_041C);
        lu_return(5'd2, 32'h22);
        lu_return(5'd3, 32'h33);
        lu_return(5'd4, 32'h44);
        lu_return(5'd10, 32'hAA);
        chk("full_clean_pending", pending, 32'd0);
        chk("full_clean_count", {29'b0, dut.u_sb.r_count}, 32'd0);

        // WAW stall and issue coinciding with a drain.
        issue(5'd6);
        id_we = 1'b1; id_dest = 5'd6;
        settle();
        chk("waw_stall", {31'b0, id_stall}, 32'd1);
        id_we = 1'b0;
        lu_valid = 1'b1; lu_dest = 5'd6; lu_data = 32'h66;
        tick();
        lu_valid = 1'b0;
        issue_valid = 1'b1; issue_dest = 5'd6;
        settle();
        chk("waw_reissue_stall", {31'b0, id_stall}, 32'd1);
        chk("waw_drain_addr", {27'b0, rf_addr}, 32'd6);
        tick();
        settle();
        chk("waw_reissue_go", {31'b0, id_stall}, 32'd0);
        tick();
        issue_valid = 1'b0;
        chk("waw_pending6", pending, 32'h40);
        chk("waw_count1", {29'b0, dut.u_sb.r_count}, 32'd1);
        lu_valid = 1'b1; lu_dest = 5'd6; lu_data = 32'h666;
        tick();
        lu_valid = 1'b0;
        issue_valid = 1'b1; issue_dest = 5'd8;
        settle();
        chk("coinc_no_stall", {31'b0, id_stall}, 32'd0);
        chk("coinc_drain_data", rf_data, 32'h666);
        tick();
        issue_valid = 1'b0;
        chk("coinc_pending", pending, 32'h100);
        chk("coinc_count", {29'b0, dut.u_sb.r_count}, 32'd1);
        lu_return(5'd8, 32'h88);

        // r0 handling.
        issue(5'd0);
        chk("r0_pending", pending, 32'd0);
        chk("r0_count", {29'b0, dut.u_sb.r_count}, 32'd1);
        rd_en_l = 1'b1; rd_addr_l = 5'd0;
        rd_en_r = 1'b1; rd_addr_r = 5'd0;
        lu_valid = 1'b1; lu_dest = 5'd0; lu_data = 32'hDEAD;
        settle();
        chk("r0_read_stall", {31'b0, id_stall}, 32'd0);
        chk("r0_lu_ready", {31'b0, lu_ready}, 32'd1);
        tick();
        lu_valid = 1'b0;
        settle();
        chk("r0_drain_no_we", {31'b0, rf_we}, 32'd0);
        chk("r0_drain_busy", {31'b0, lu_ready}, 32'd0);
        tick();
        chk("r0_ready_again", {31'b0, lu_ready}, 32'd1);
        chk("r0_count_zero", {29'b0, dut.u_sb.r_count}, 32'd0);
        rd_en_l = 1'b0; rd_en_r = 1'b0;

        // Reset mid-operation with a buffered result.
        issue(5'd4);
        issue(5'd5);
        issue(5'd6);
        issue(5'd7);
        chk("mid_pending", pending, 32'h0000_00F0);
        lu_valid = 1'b1; lu_dest = 5'd4; lu_data = 32'h4444;
        tick();
        lu_valid = 1'b0;
        chk("mid_buf_full", {31'b0, lu_ready}, 32'd0);
        rst = 1'b1;
        rd_en_l = 1'b1; rd_addr_l = 5'd5;
        settle();
        chk("mid_rst_we", {31'b0, rf_we}, 32'd0);
        chk("mid_rst_stall", {31'b0, id_stall}, 32'd0);
        tick();
        chk("mid_rst_pending", pending, 32'd0);
        rst = 1'b0;
        rd_en_l = 1'b0;
        settle();
        chk("mid_after_ready", {31'b0, lu_ready}, 32'd1);
        chk("mid_after_we", {31'b0, rf_we}, 32'd0);
        chk("mid_after_count", {29'b0, dut.u_sb.r_count}, 32'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
